// File: rtl/rvfi_retire_serializer_if.sv
// Retirement bus between a multi-issue core's RVFI outputs and a single-channel checker.
// The serializer takes the slave side; the core/checker wrapper takes the master side.
interface rvfi_retire_serializer_if #(
    parameter int unsigned NRET  = 2,
    parameter int unsigned REC_W = 320
);
    logic [NRET-1:0]       in_valid;
    logic [NRET*REC_W-1:0] in_rec;
    logic                  out_valid;
    logic                  out_ready;
    logic [REC_W-1:0]      out_rec;

    modport master (output in_valid, in_rec, out_ready, input out_valid, out_rec);
    modport slave  (input in_valid, in_rec, out_ready, output out_valid, out_rec);
endinterface

// File: rtl/rvfi_retire_serializer.sv
// Funnels up to NRET retirement records per cycle into one record per cycle through a FIFO,
// checking that rvfi_order advances by one and latching a terminal fault on overflow.
module rvfi_retire_serializer #(
    parameter int unsigned NRET    = 2,
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ORDER_W = 8,
    parameter int unsigned DEPTH   = 8
) (
    input  logic                         clk,
    input  logic                         resetn,
    rvfi_retire_serializer_if.slave      bus,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow,
    output logic                         order_err,
    output logic [31:0]                  retired
);
    localparam int unsigned REC_W = ORDER_W + 32 + 15 + 1 + 8*XLEN + 2*(XLEN/8);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);
    localparam int unsigned CNT_W = $clog2(NRET + 1);

    typedef enum logic [1:0] {EMPTY, ACTIVE, FAULT} state_t;

    state_t               state, state_d;
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [ORDER_W-1:0]   last_order, last_d;
    logic                 have_base, have_d;
    logic [REC_W-1:0]     mem [DEPTH];

    logic [CNT_W-1:0]     npush;
    logic [PTR_W-1:0]     slot [NRET];
    logic                 pop;
    logic [LVL_W:0]       fill;
    logic                 accept;
    logic                 reject;
    logic                 ord_bad;
    logic [ORDER_W-1:0]   rec_ord;
    logic [LVL_W-1:0]     level_d;

    // Slot assignment, space check and order tracking for this cycle's batch
    always_comb begin
        npush   = '0;
        ord_bad = 1'b0;
        last_d  = last_order;
        have_d  = have_base;
        rec_ord = '0;
        for (int unsigned c = 0; c < NRET; c++) begin
            slot[c] = wr_ptr + PTR_W'(npush);
            if (bus.in_valid[c]) npush = npush + CNT_W'(1);
        end
        pop     = bus.out_valid && bus.out_ready;
        fill    = (LVL_W+1)'(level) - (LVL_W+1)'(pop) + (LVL_W+1)'(npush);
        accept  = (state != FAULT) && (fill <= (LVL_W+1)'(DEPTH));
        reject  = (state != FAULT) && !accept;
        level_d = accept ? LVL_W'(fill) : level - LVL_W'(pop);
        if (accept) begin
            for (int unsigned c = 0; c < NRET; c++) begin
                if (bus.in_valid[c]) begin
                    rec_ord = bus.in_rec[c*REC_W +: ORDER_W];
                    if (have_d && (rec_ord != last_d + ORDER_W'(1))) ord_bad = 1'b1;
                    last_d = rec_ord;
                    have_d = 1'b1;
                end
            end
        end
    end

    // Next-state logic; FAULT holds until reset
    always_comb begin
        state_d = state;
        case (state)
            EMPTY:   if (level_d != '0) state_d = ACTIVE;
            ACTIVE:  if (level_d == '0) state_d = EMPTY;
            FAULT:   state_d = FAULT;
            default: state_d = FAULT;
        endcase
        if (reject) state_d = FAULT;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= EMPTY;
        else         state <= state_d;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            overflow   <= 1'b0;
            order_err  <= 1'b0;
            retired    <= '0;
            last_order <= '0;
            have_base  <= 1'b0;
        end else begin
            level     <= level_d;
            rd_ptr    <= rd_ptr + PTR_W'(pop);
            retired   <= retired + 32'(pop);
            overflow  <= overflow | reject;
            order_err <= order_err | ord_bad;
            if (accept) begin
                wr_ptr     <= wr_ptr + PTR_W'(npush);
                last_order <= last_d;
                have_base  <= have_d;
            end
        end
    end

    // Record storage carries no reset; occupancy and pointers define validity
    always_ff @(posedge clk) begin
        for (int unsigned c = 0; c < NRET; c++) begin
            if (accept && bus.in_valid[c]) mem[slot[c]] <= bus.in_rec[c*REC_W +: REC_W];
        end
    end

    assign bus.out_valid = (level != '0) && (state == ACTIVE);
    assign bus.out_rec   = mem[rd_ptr];
endmodule
